// File: rtl/keypad_entry_encoder_pkg.sv
// Shared types and helpers for the keypad entry encoder.
// Holds the FSM state encodings, default key geometry and clog2 helper.
package keypad_entry_encoder_pkg;

  typedef enum logic {
    KP_IDLE    = 1'b0,
    KP_PRESSED = 1'b1
  } kp_state_e;

  localparam int KP_NUM_KEYS = 10;
  localparam int KP_CODE_W   = 4;

  function automatic int kp_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_entry_encoder_debouncer.sv
// key_debouncer: two-flop synchroniser plus whole-vector debounce counter.
// deb takes the synchronised vector after DEBOUNCE_CYCLES stable samples.
module key_debouncer
  import keypad_entry_encoder_pkg::*;
#(
  parameter int W               = KP_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] deb
);

  localparam logic [7:0] DC = 8'(DEBOUNCE_CYCLES);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;
  logic [W-1:0] deb_q, deb_d;
  logic [7:0]   cnt_q, cnt_d;

  // s1 != s2 means s2 is about to change on this edge
  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (s1_q != s2_q) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != DC) cnt_d = cnt_q + 8'd1;
      if (cnt_q == DC - 8'd1) deb_d = s2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      cnt_q <= '0;
      deb_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/keypad_entry_encoder.sv
// Debounced keypad encoder with one-pulse-per-press codes and entry register.
// Optional MULTI_KEY_REJECT_EN rejects presses with more than one key down.
module keypad_entry_encoder
  import keypad_entry_encoder_pkg::*;
#(
  parameter  int NUM_KEYS        = KP_NUM_KEYS,
  parameter  int CODE_W          = KP_CODE_W,
  parameter  int DEBOUNCE_CYCLES = 4,
  parameter  int DIGITS          = 4,
  localparam int CNT_W           = kp_clog2(DIGITS + 1),
  localparam int EW              = DIGITS * CODE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_in,
  input  logic                clear,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic [EW-1:0]       entry,
  output logic [CNT_W-1:0]    entry_count,
  output logic                entry_done,
  output logic                multi_err
);

  logic [NUM_KEYS-1:0] deb;
  logic [CODE_W-1:0]   enc;
  logic                accept;

  kp_state_e         state_q, state_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic [EW-1:0]     entry_q, entry_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, done_d;

  key_debouncer #(
    .W               (NUM_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .clk (clk),
    .rst (rst),
    .raw (keys_in),
    .deb (deb)
  );

  // highest set index wins
  always_comb begin
    enc = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (deb[i]) enc = CODE_W'(i);
    end
  end

`ifdef MULTI_KEY_REJECT_EN
  logic multi;
  logic multi_err_q, multi_err_d;
  assign multi = |(deb & (deb - 1'b1));
`endif

  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    entry_d     = entry_q;
    count_d     = count_q;
    accept      = 1'b0;
`ifdef MULTI_KEY_REJECT_EN
    multi_err_d = 1'b0;
`endif
    unique case (state_q)
      KP_IDLE: begin
        if (|deb) begin
          state_d = KP_PRESSED;
`ifdef MULTI_KEY_REJECT_EN
          if (multi) multi_err_d = 1'b1;
          else       accept      = 1'b1;
`else
          accept = 1'b1;
`endif
        end
      end
      KP_PRESSED: begin
        if (deb == '0) state_d = KP_IDLE;
      end
      default: state_d = KP_IDLE;
    endcase
    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = enc;
    end
    // clear beats a coincident store
    if (clear) begin
      entry_d = '0;
      count_d = '0;
    end else if (accept && count_q < CNT_W'(DIGITS)) begin
      entry_d = (entry_q << CODE_W) | EW'(enc);
      count_d = count_q + 1'b1;
    end
    done_d = (count_d == CNT_W'(DIGITS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= KP_IDLE;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      entry_q     <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      entry_q     <= entry_d;
      count_q     <= count_d;
      done_q      <= done_d;
    end
  end

`ifdef MULTI_KEY_REJECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) multi_err_q <= 1'b0;
    else     multi_err_q <= multi_err_d;
  end
  assign multi_err = multi_err_q;
`else
  assign multi_err = 1'b0;
`endif

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign entry       = entry_q;
  assign entry_count = count_q;
  assign entry_done  = done_q;

endmodule

// File: tb/tb_keypad_entry_encoder.sv
// Randomised and directed bench for keypad_entry_encoder.
// Reference model works on sample history and a queue of stored codes.
module tb_keypad_entry_encoder;

  localparam int NK = 10;
  localparam int CW = 4;
  localparam int D  = 4;
  localparam int DG = 4;
  localparam int EW = DG * CW;
  localparam int CN = 3;

  logic          clk = 0;
  logic          rst = 1;
  logic [NK-1:0] keys_in = '0;
  logic          clear = 0;
  logic [CW-1:0] key_code;
  logic          key_valid;
  logic [EW-1:0] entry;
  logic [CN-1:0] entry_count;
  logic          entry_done;
  logic          multi_err;

  int total = 0;
  int bad   = 0;
  int kv_seen = 0;

  keypad_entry_encoder #(
    .NUM_KEYS        (NK),
    .CODE_W          (CW),
    .DEBOUNCE_CYCLES (D),
    .DIGITS          (DG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keys_in     (keys_in),
    .clear       (clear),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .entry       (entry),
    .entry_count (entry_count),
    .entry_done  (entry_done),
    .multi_err   (multi_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NK-1:0] hist [0:D];
  logic [NK-1:0] mdeb;
  bit            mpress;
  logic [CW-1:0] mcode;
  bit            mvalid;
  bit            merr;
  int            q[$];

  function automatic int highest(input logic [NK-1:0] v);
    for (int i = NK - 1; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int ones(input logic [NK-1:0] v);
    int n = 0;
    for (int i = 0; i < NK; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [EW-1:0] m_entry();
    logic [EW-1:0] e = '0;
    for (int k = 0; k < q.size(); k++)
      e |= EW'(q[q.size() - 1 - k]) << (k * CW);
    return e;
  endfunction

  initial begin
    for (int i = 0; i <= D; i++) hist[i] = '0;
    mdeb = '0; mpress = 0; mcode = '0; mvalid = 0; merr = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i <= D; i++) hist[i] = '0;
        mdeb = '0; mpress = 0; mcode = '0; mvalid = 0; merr = 0;
        q.delete();
      end else begin
        bit acc;
        bit stable;
        acc = 0; mvalid = 0; merr = 0;
        if (!mpress && mdeb != 0) begin
          mpress = 1;
`ifdef MULTI_KEY_REJECT_EN
          if (ones(mdeb) > 1) merr = 1;
          else acc = 1;
`else
          acc = 1;
`endif
          if (acc) begin
            mvalid = 1;
            mcode  = CW'(highest(mdeb));
          end
        end else if (mpress && mdeb == 0) begin
          mpress = 0;
        end
        if (clear) q.delete();
        else if (acc && q.size() < DG) q.push_back(int'(mcode));
        stable = 1;
        for (int i = 1; i <= D; i++) if (hist[i] != hist[0]) stable = 0;
        if (stable) mdeb = hist[0];
        for (int i = D; i >= 1; i--) hist[i] = hist[i-1];
        hist[0] = keys_in;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("key_valid", 32'(key_valid), 32'(mvalid));
        chk("key_code", 32'(key_code), 32'(mcode));
        chk("entry", 32'(entry), 32'(m_entry()));
        chk("entry_count", 32'(entry_count), 32'(q.size()));
        chk("entry_done", 32'(entry_done), 32'(q.size() == DG));
        chk("multi_err", 32'(multi_err), 32'(merr));
        if (key_valid) kv_seen++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input int k, input int hold, input int gap);
    @(negedge clk);
    keys_in = '0;
    keys_in[k] = 1'b1;
    repeat (hold) @(negedge clk);
    keys_in = '0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int kv0;
    // 1: reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_code", 32'(key_code), 0);
    chk("rst_entry", 32'(entry), 0);
    chk("rst_count", 32'(entry_count), 0);
    chk("rst_valid", 32'(key_valid), 0);
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("idle_no_valid", 32'(kv_seen), 0);

    // 2: key 7, latency exactly 7 edges
    keys_in[7] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("lat_edge6", 32'(key_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_edge7", 32'(key_valid), 1);
    chk("t2_code", 32'(key_code), 7);
    chk("t2_entry", 32'(entry), 32'h0007);
    chk("t2_count", 32'(entry_count), 1);
    repeat (5) @(negedge clk);
    keys_in = '0;
    repeat (10) @(negedge clk);

    // 3: glitch of 3 cycles
    kv0 = kv_seen;
    press(3, 3, 15);
    chk("glitch_no_valid", 32'(kv_seen - kv0), 0);
    chk("glitch_entry", 32'(entry), 32'h0007);

    // 4: fill register, then overflow press
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    kv0 = kv_seen;
    press(1, 10, 10);
    press(9, 10, 10);
    press(0, 10, 10);
    press(7, 10, 10);
    chk("t4_entry", 32'(entry), 32'h1907);
    chk("t4_done", 32'(entry_done), 1);
    press(5, 10, 10);
    chk("t4_full_entry", 32'(entry), 32'h1907);
    chk("t4_pulses", 32'(kv_seen - kv0), 5);
    chk("t4_code", 32'(key_code), 5);

    // 5: clear coincident with accept of key 2
    @(negedge clk);
    keys_in = '0;
    keys_in[2] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    clear = 1;
    @(posedge clk);
    #1;
    chk("t5_valid", 32'(key_valid), 1);
    chk("t5_code", 32'(key_code), 2);
    chk("t5_entry", 32'(entry), 0);
    chk("t5_count", 32'(entry_count), 0);
    @(negedge clk);
    clear = 0;
    repeat (4) @(negedge clk);
    keys_in = '0;
    repeat (10) @(negedge clk);

    // 6: two keys together
    keys_in[2] = 1'b1;
    keys_in[8] = 1'b1;
    repeat (7) @(posedge clk);
    #1;
`ifdef MULTI_KEY_REJECT_EN
    chk("t6_multi_err", 32'(multi_err), 1);
    chk("t6_no_valid", 32'(key_valid), 0);
`else
    chk("t6_valid", 32'(key_valid), 1);
    chk("t6_code", 32'(key_code), 8);
`endif
    @(negedge clk);
    keys_in = '0;
    repeat (10) @(negedge clk);

    // reset mid-press with key still held
    keys_in[4] = 1'b1;
    repeat (9) @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_code", 32'(key_code), 0);
    chk("mid_rst_entry", 32'(entry), 0);
    chk("mid_rst_count", 32'(entry_count), 0);
    @(negedge clk);
    rst = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_lat_edge6", 32'(key_valid), 0);
    @(posedge clk);
    #1;
    chk("rst_lat_edge7", 32'(key_valid), 1);
    chk("rst_lat_code", 32'(key_code), 4);
    @(negedge clk);
    keys_in = '0;
    repeat (10) @(negedge clk);

    // random phase
    for (int it = 0; it < 300; it++) begin
      int sel = $urandom_range(0, 99);
      int dur = $urandom_range(1, 14);
      int gap = $urandom_range(0, 10);
      logic [NK-1:0] pat = '0;
      if (sel < 70) pat[$urandom_range(0, NK - 1)] = 1'b1;
      else if (sel < 85) begin
        pat[$urandom_range(0, NK - 1)] = 1'b1;
        pat[$urandom_range(0, NK - 1)] = 1'b1;
      end
      for (int c = 0; c < dur; c++) begin
        keys_in = pat;
        clear = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      keys_in = '0;
      for (int c = 0; c < gap; c++) begin
        clear = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      clear = 0;
    end
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
